// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-dump reader: default geometry, FSM encoding
// and beat field widths. Checksum beat is enabled by defining REG_DUMP_CHECKSUM_EN.
package reg_dump_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_SEND  = 3'd2;
  localparam logic [2:0] ST_CSUM  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_SEND  = ST_SEND,
    S_CSUM  = ST_CSUM,
    S_DONE  = ST_DONE
  } state_t;

  // A beat carries index, data and the csum/last flags.
  localparam int BEAT_FLAGS_W = 2;
  localparam int BEAT_W       = ADDR_W_DEF + DATA_W_DEF + BEAT_FLAGS_W;

endpackage

// File: rtl/reg_dump_out_stage.sv
// One-entry output holding register for the dump stream: loads a beat, holds it
// while the consumer stalls, and drops valid/last/csum on accept or abort.
module reg_dump_out_stage
  import reg_dump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_index,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_csum,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_csum,
  output logic              out_last,
  output logic              accept
);

  assign accept = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      out_csum  <= 1'b0;
      out_last  <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_csum  <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_index <= load_index;
      out_data  <= load_data;
      out_csum  <= load_csum;
      out_last  <= load_last;
    end else if (accept) begin
      // index/data are left in place; only the qualifiers drop
      out_valid <= 1'b0;
      out_csum  <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: walks every register-file index and streams (index, data)
// over valid/ready. Define REG_DUMP_CHECKSUM_EN to append an XOR checksum beat.
//
// state | meaning
// IDLE  | waiting for start, read address parked at 0
// FETCH | read address = idx, snapshot read data into the output stage
// SEND  | beat held on out_* until accepted
// CSUM  | checksum beat loaded then held until accepted
// DONE  | one-cycle done pulse, back to IDLE
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_csum,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] idx, idx_d;
  logic              ld, clr, accept;
  logic [ADDR_W-1:0] ld_index;
  logic [DATA_W-1:0] ld_data;
  logic              ld_csum, ld_last;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum, csum_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum <= '0;
    else        csum <= csum_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    ld       = 1'b0;
    clr      = 1'b0;
    ld_index = idx;
    ld_data  = rd_data;
    ld_csum  = 1'b0;
    ld_last  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d   = csum;
`endif
    // abort beats any accept on the same edge, so no done pulse can follow it
    if (abort && state != S_IDLE) begin
      clr     = 1'b1;
      idx_d   = '0;
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            idx_d   = '0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_d  = '0;
`endif
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          ld      = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d  = csum ^ rd_data;
`else
          ld_last = (idx == LAST_IDX);
`endif
          state_d = S_SEND;
        end
        S_SEND: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end else begin
              idx_d   = idx + ADDR_W'(1);
              state_d = S_FETCH;
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        S_CSUM: begin
          if (!out_valid) begin
            ld       = 1'b1;
            ld_index = '0;
            ld_data  = csum;
            ld_csum  = 1'b1;
            ld_last  = 1'b1;
          end else if (accept) begin
            state_d = S_DONE;
          end
        end
`endif
        S_DONE: begin
          idx_d   = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Address depends only on registered state, never on out_ready.
  assign rd_addr = (state == S_FETCH) ? idx : '0;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

  reg_dump_out_stage #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ld),
    .clear      (clr),
    .load_index (ld_index),
    .load_data  (ld_data),
    .load_csum  (ld_csum),
    .load_last  (ld_last),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_index  (out_index),
    .out_data   (out_data),
    .out_csum   (out_csum),
    .out_last   (out_last),
    .accept     (accept)
  );

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader with a behavioural 32x32 register file.
// Honours REG_DUMP_CHECKSUM_EN to expect the extra checksum beat.
module tb_reg_dump_reader;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NB = NR + CS;
  // start edge plus two cycles per register (plus two for the checksum beat)
  localparam int DONE_CYC = 2 * NR + 1 + 2 * CS;

  typedef struct {
    logic [DW-1:0] rf_init;
    logic [AW-1:0] index;
    logic [DW-1:0] data;
    logic          last;
    logic          csum;
  } vec_t;

  typedef struct {
    logic [AW-1:0] index;
    logic [DW-1:0] data;
    logic          last;
    logic          csum;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, out_ready;
  logic [AW-1:0] rd_addr, out_index;
  logic [DW-1:0] rd_data, out_data;
  logic          out_valid, out_csum, out_last, busy, done;

  logic [DW-1:0] regs [NR];
  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  reg_dump_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_data  (out_data),
    .out_csum  (out_csum),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  vec_t  tbl [NB];
  beat_t got [$];
  int    nchk = 0;
  int    nerr = 0;
  int    done_cnt, done_cyc, first_vc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic run_dump(input int stall_beat, input int stall_len, input int write_idx,
                          input int restart_cyc);
    int  stalled;
    bit  fin;
    stalled  = 0;
    fin      = 1'b0;
    got.delete();
    done_cnt = 0;
    done_cyc = -1;
    first_vc = -1;
    start     = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 400 && !fin; c++) begin
      @(negedge clk);
      start = (c == restart_cyc);
      if (out_valid && first_vc < 0) first_vc = c;
      if (out_valid && got.size() == stall_beat && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
        chk("stall_index", 64'(out_index), 64'(tbl[stall_beat].index));
        chk("stall_data", 64'(out_data), 64'(tbl[stall_beat].data));
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        got.push_back('{out_index, out_data, out_last, out_csum});
        if (!out_csum && int'(out_index) == write_idx) regs[write_idx] = 32'hDEAD_BEEF;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (done_cyc >= 0 && !busy) fin = 1'b1;
    end
    if (!fin) timeout_fail("dump_complete");
    start     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_beats(input string tag, input int exp_done_cyc);
    chk({tag, "_beat_count"}, 64'(got.size()), 64'(NB));
    for (int i = 0; i < NB; i++) begin
      if (i < got.size()) begin
        chk($sformatf("%s_b%0d_index", tag, i), 64'(got[i].index), 64'(tbl[i].index));
        chk($sformatf("%s_b%0d_data", tag, i), 64'(got[i].data), 64'(tbl[i].data));
        chk($sformatf("%s_b%0d_last", tag, i), 64'(got[i].last), 64'(tbl[i].last));
        chk($sformatf("%s_b%0d_csum", tag, i), 64'(got[i].csum), 64'(tbl[i].csum));
      end
    end
    chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done_cyc));
  endtask

  task automatic wait_index(input int k, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && int'(out_index) == k) ok = 1'b1;
    end
    if (!ok) timeout_fail($sformatf("reach_index_%0d", k));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen_done;

    for (int i = 0; i < NR; i++) begin
      tbl[i].rf_init = '0;
      tbl[i].index   = AW'(i);
      tbl[i].data    = '0;
      tbl[i].last    = (i == NR - 1) && (CS == 0);
      tbl[i].csum    = 1'b0;
    end
    tbl[8].rf_init = 32'd5;
    tbl[8].data    = 32'd5;
    tbl[9].rf_init = 32'd3;
    tbl[9].data    = 32'd3;
`ifdef REG_DUMP_CHECKSUM_EN
    tbl[NR] = '{'0, '0, 32'h0000_0006, 1'b1, 1'b1};
`endif
    for (int i = 0; i < NR; i++) regs[i] = tbl[i].rf_init;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_csum", 64'(out_csum), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // full dump, ready high, with a stray start pulse mid-dump
    run_dump(-1, 0, -1, 11);
    check_beats("basic", DONE_CYC);
    chk("basic_latency", 64'(first_vc), 64'd2);
    @(negedge clk);

    // consumer stalls 5 cycles on beat 8
    run_dump(8, 5, -1, -1);
    check_beats("stall", DONE_CYC + 5);
    @(negedge clk);

    // r9 overwritten as its beat is accepted; snapshot must still show 3
    run_dump(-1, 0, 9, -1);
    check_beats("snap", DONE_CYC);
    chk("snap_reg_written", 64'(regs[9]), 64'hDEAD_BEEF);
    regs[9] = 32'd3;
    @(negedge clk);

    // abort while idx 12 is stalled
    start = 1'b1;
    out_ready = 1'b1;
    wait_index(12, ok);
    out_ready = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort12_valid", 64'(out_valid), 64'd0);
    chk("abort12_busy", 64'(busy), 64'd0);
    chk("abort12_done", 64'(done), 64'd0);
    chk("abort12_rd_addr", 64'(rd_addr), 64'd0);
    out_ready = 1'b1;

    // abort on the same edge that accepts the final register beat
    start = 1'b1;
    wait_index(NR - 1, ok);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort31_valid", 64'(out_valid), 64'd0);
    chk("abort31_last", 64'(out_last), 64'd0);
    chk("abort31_busy", 64'(busy), 64'd0);
    seen_done = done;
    repeat (4) begin
      @(negedge clk);
      seen_done |= done;
    end
    chk("abort31_no_done", 64'(seen_done), 64'd0);

    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("start_abort_idle_busy2", 64'(busy), 64'd0);

    run_dump(-1, 0, -1, -1);
    check_beats("restart", DONE_CYC);
    @(negedge clk);

    // asynchronous reset in the middle of beat 20
    start = 1'b1;
    wait_index(20, ok);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_out_index", 64'(out_index), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_rd_addr", 64'(rd_addr), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_still_idle", 64'(busy), 64'd0);

    run_dump(-1, 0, -1, -1);
    check_beats("post_rst", DONE_CYC);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
